ghash_mul_ds: RTL and testbench

- Parametrised digit-serial GF(2^128) multiplier for the GCM GHASH path; successor to the bit-serial gfmul_v2.
- Computes Z = X•H in the GCM field (polynomial x^128+x^7+x^2+x+1, GCM reflected bit order).
- The per-cycle digit width sets the area/latency trade-off.
- Adds an internal GHASH accumulator (Y <- (Y^X)•H), a registered hash key and a ready/valid input handshake, so the GCM controller can chain blocks without external XOR and feedback logic.

---
 rtl/ghash_mul_ds.sv | 113 +++++++++++
 tb/tb_ghash_mul_ds.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ghash_mul_ds.sv
// ghash_mul_ds: digit-serial GF(2^128) GHASH multiplier with accumulator, key register and ready/valid input
//   iClk, iRstn               clock (rising edge), asynchronous active-low reset
//   iData, iData_valid        128-bit block X, accepted when iData_valid && oReady
//   iAccum                    sampled with data: operand = iData ^ Y when 1, iData when 0
//   iHashkey, iHashkey_valid  hash key H, loaded only while oReady
//   oReady                    idle, a data beat or a key can be taken
//   oKey_valid                a key has been loaded since reset
//   oResult, oResult_valid    product Z (also accumulator Y), one-cycle pulse on update
module ghash_mul_ds #(
    parameter int DIGIT = 8
) (
    input  logic         iClk,
    input  logic         iRstn,
    input  logic [127:0] iData,
    input  logic         iData_valid,
    input  logic         iAccum,
    input  logic [127:0] iHashkey,
    input  logic         iHashkey_valid,
    output logic         oReady,
    output logic         oKey_valid,
    output logic [127:0] oResult,
    output logic         oResult_valid
);
    localparam int N = 128 / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [127:0] R = {8'hE1, 120'd0};

    if (DIGIT != 1 && DIGIT != 2 && DIGIT != 4 && DIGIT != 8 && DIGIT != 16 &&
        DIGIT != 32 && DIGIT != 64 && DIGIT != 128) begin : g_bad_digit
        $error("DIGIT must be a power of two from 1 to 128");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [127:0]   r_h;
    logic           r_key_valid;
    logic [127:0]   r_x;
    logic [127:0]   r_z;
    logic [127:0]   r_v;
    logic [CW-1:0]  r_cnt;
    logic [127:0]   r_y;
    logic           r_valid;
    logic [127:0]   w_z;
    logic [127:0]   w_v;
    logic           w_accept;
    logic           w_key_load;
    logic           w_done;

    assign w_accept   = iData_valid && oReady;
    assign w_key_load = iHashkey_valid && oReady;
    assign w_done     = (r_state == BUSY) && (r_cnt == CW'(N - 1));

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (w_accept ? BUSY : IDLE) : (w_done ? IDLE : BUSY);
    end

    always_comb begin
        oReady = (r_state == IDLE);
    end

    // DIGIT bit steps of the shift-and-add multiply, x^0 coefficient (MSB) first
    always_comb begin
        w_z = r_z;
        w_v = r_v;
        for (int i = 0; i < DIGIT; i++) begin
            w_z = r_x[127-i] ? (w_z ^ w_v) : w_z;
            w_v = w_v[0] ? ((w_v >> 1) ^ R) : (w_v >> 1);
        end
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_h         <= '0;
            r_key_valid <= 1'b0;
            r_x         <= '0;
            r_z         <= '0;
            r_v         <= '0;
            r_cnt       <= '0;
            r_y         <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= w_done;
            if (w_key_load) begin
                r_h         <= iHashkey;
                r_key_valid <= 1'b1;
            end
            if (w_accept) begin
                // Y is already final in the result cycle, so accumulation needs no bubble
                r_x   <= iAccum ? (iData ^ r_y) : iData;
                r_z   <= '0;
                r_v   <= w_key_load ? iHashkey : r_h;
                r_cnt <= '0;
            end else if (r_state == BUSY) begin
                r_x   <= r_x << DIGIT;
                r_z   <= w_z;
                r_v   <= w_v;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_done) r_y <= w_z;
        end
    end

    assign oKey_valid    = r_key_valid;
    assign oResult       = r_y;
    assign oResult_valid = r_valid;
endmodule

// File: tb/tb_ghash_mul_ds.sv
// tb_ghash_mul_ds: table-driven and scoreboard check of ghash_mul_ds across several digit widths
module tb_ghash_mul_ds;
    localparam logic [127:0] H1 = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
    localparam logic [127:0] X1 = 128'h0388DACE60B6A392F328C2B971B2FE78;
    localparam logic [127:0] Z1 = 128'h5E2EC746917062882C85B0685353DEB7;
    localparam logic [127:0] H2 = 128'h73A23D80121DE2D5A850253FCF43120E;
    localparam logic [127:0] X2 = 128'hD609B1F056637A0D46DF998D88E52E00;
    localparam logic [127:0] Z2 = 128'h9CABBD91899C1413AA7AD629C1DF12CD;
    localparam logic [127:0] X3 = 128'hB2C2846512153524C0895E8100000000;
    localparam logic [127:0] Z3 = 128'hB99ABF6BDBD18B8E148F8030F0686F28;
    localparam logic [127:0] ONE = 128'h80000000000000000000000000000000;

    typedef struct {
        logic [127:0] key;
        logic         kl;
        logic [127:0] data;
        logic         acc;
        logic [127:0] exp;
    } vec_t;

    typedef struct {
        logic [127:0] exp;
        int           acc;
    } sb_t;

    logic         clk = 0;
    logic         rst_n = 0;
    logic [127:0] data = '0;
    logic         dv = 0;
    logic         acc = 0;
    logic [127:0] key = '0;
    logic         kv = 0;
    logic [127:0] res [5];
    logic         rdy [5];
    logic         kvo [5];
    logic         rv [5];

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  last_acc = 0;
    logic prev_rv = 0;
    logic [127:0] ym = '0;
    logic [127:0] hm = '0;
    sb_t sbq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        ghash_mul_ds #(.DIGIT(g == 0 ? 8 : g == 1 ? 1 : g == 2 ? 4 : g == 3 ? 32 : 128)) dut (
            .iClk(clk), .iRstn(rst_n), .iData(data), .iData_valid(dv), .iAccum(acc),
            .iHashkey(key), .iHashkey_valid(kv), .oReady(rdy[g]), .oKey_valid(kvo[g]),
            .oResult(res[g]), .oResult_valid(rv[g]));
    end

    function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] h);
        logic [127:0] z = '0;
        logic [127:0] v = h;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'hE1, 120'd0}) : (v >> 1);
        end
        return z;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic a, input logic [127:0] k,
                        input logic kl, input logic [127:0] exp);
        sb_t e;
        int n = 0;
        @(negedge clk);
        while (!rdy[0] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[0]) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout got=0 want=1");
        end
        data = d; dv = 1; acc = a; key = k; kv = kl;
        if (kl) hm = k;
        ym = exp;
        @(posedge clk);
        #1;
        dv = 0; kv = 0;
        e.exp = exp;
        e.acc = cyc;
        last_acc = cyc;
        sbq.push_back(e);
    endtask

    // scoreboard on the DIGIT=8 instance: result value, latency and single-cycle pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (rv[0]) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse got=%h want=none", res[0]);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("result", res[0], e.exp);
                    chk("latency", 128'(cyc - e.acc), 128'(16));
                end
                if (prev_rv) begin
                    checks++;
                    failures++;
                    $display("FAIL pulse_width got=2+ want=1");
                end
            end
            prev_rv = rv[0];
        end else prev_rv = 0;
    end

    initial begin
        vec_t tbl [6];
        int prev_acc;
        int lat [5];
        logic [127:0] rr [5];
        logic [127:0] d, k, e;
        logic a, kl;

        tbl[0] = '{key: '0, kl: 0, data: X1,  acc: 0, exp: '0};
        tbl[1] = '{key: H1, kl: 1, data: X1,  acc: 0, exp: Z1};
        tbl[2] = '{key: '0, kl: 0, data: ONE, acc: 0, exp: H1};
        tbl[3] = '{key: '0, kl: 0, data: '0,  acc: 0, exp: '0};
        tbl[4] = '{key: H2, kl: 1, data: X2,  acc: 0, exp: Z2};
        tbl[5] = '{key: '0, kl: 0, data: X3,  acc: 1, exp: Z3};

        repeat (2) @(negedge clk);
        chk("rst_ready", 128'(rdy[0]), 128'(1));
        chk("rst_keyvalid", 128'(kvo[0]), 128'(0));
        chk("rst_result", res[0], '0);
        chk("rst_rvalid", 128'(rv[0]), 128'(0));
        rst_n = 1;

        prev_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].data, tbl[i].acc, tbl[i].key, tbl[i].kl, tbl[i].exp);
            if (i == 0) chk("no_key_keyvalid", 128'(kvo[0]), 128'(0));
            if (i == 1) chk("keyvalid_set", 128'(kvo[0]), 128'(1));
            if (i == 5) chk("back_to_back_gap", 128'(last_acc - prev_acc), 128'(17));
            prev_acc = last_acc;
        end

        for (int i = 0; i < 3; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            a = 1'($urandom_range(0, 1));
            kl = 1'($urandom_range(0, 1));
            e = gmul(a ? (d ^ ym) : d, kl ? k : hm);
            send(d, a, k, kl, e);
        end

        // key pulse while busy must not disturb the current or the next multiply
        send(ONE, 0, '0, 0, hm);
        repeat (5) @(negedge clk);
        chk("busy_ready", 128'(rdy[0]), 128'(0));
        key = H1; kv = 1;
        @(negedge clk);
        kv = 0;
        send(ONE, 0, '0, 0, hm);

        // reset in busy cycle 5 aborts with no pulse and clears Y and H
        send(X2, 0, '0, 0, gmul(X2, hm));
        repeat (4) @(negedge clk);
        rst_n = 0;
        #1;
        chk("abort_result", res[0], '0);
        chk("abort_ready", 128'(rdy[0]), 128'(1));
        chk("abort_rvalid", 128'(rv[0]), 128'(0));
        chk("abort_keyvalid", 128'(kvo[0]), 128'(0));
        sbq.delete();
        ym = '0;
        hm = '0;
        @(negedge clk);
        rst_n = 1;
        repeat (20) @(negedge clk);
        send(X1, 1, H1, 1, Z1);

        // all digit widths together from a fresh reset
        repeat (20) @(negedge clk);
        rst_n = 0;
        sbq.delete();
        ym = '0;
        hm = '0;
        @(negedge clk);
        rst_n = 1;
        for (int g = 0; g < 5; g++) begin
            lat[g] = -1;
            rr[g] = '0;
        end
        send(X1, 0, H1, 1, Z1);
        for (int t = 0; t < 200; t++) begin
            for (int g = 0; g < 5; g++)
                if (rv[g] && lat[g] < 0) begin
                    lat[g] = cyc - last_acc;
                    rr[g] = res[g];
                end
            @(negedge clk);
        end
        chk("d1_result", rr[1], Z1);
        chk("d1_latency", 128'(lat[1]), 128'(128));
        chk("d4_result", rr[2], Z1);
        chk("d4_latency", 128'(lat[2]), 128'(32));
        chk("d32_result", rr[3], Z1);
        chk("d32_latency", 128'(lat[3]), 128'(4));
        chk("d128_result", rr[4], Z1);
        chk("d128_latency", 128'(lat[4]), 128'(1));

        for (int t = 0; t < 300 && sbq.size() != 0; t++) @(negedge clk);
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain got=%0d want=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
